// File: rtl/rf_issue_if.sv
// Handshake and control bundle between fetch, the issue controller, the
// register file, the ALU and memory.
//   inst_*   : instruction valid/ready handshake and 32-bit word
//   rf_*     : register file func/en_rg/addr/imm controls
//   alu_*    : ALU opcode, start pulse and done strobe
//   mem_*    : memory request/ack, write enable and address
//   retire, err, retire_cnt : completion, error and retired count
// master = issue controller side, slave = environment side.
interface rf_issue_if;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [1:0]  rf_func;
   logic        rf_en_rg;
   logic [23:0] rf_addr;
   logic [7:0]  rf_imm;
   logic [3:0]  alu_op;
   logic        alu_start;
   logic        alu_done;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic        retire;
   logic        err;
   logic [15:0] retire_cnt;

   modport master (
      input  inst_valid, inst_data, alu_done, mem_ack,
      output inst_ready, rf_func, rf_en_rg, rf_addr, rf_imm, alu_op, alu_start,
             mem_req, mem_we, mem_addr, retire, err, retire_cnt
   );

   modport slave (
      output inst_valid, inst_data, alu_done, mem_ack,
      input  inst_ready, rf_func, rf_en_rg, rf_addr, rf_imm, alu_op, alu_start,
             mem_req, mem_we, mem_addr, retire, err, retire_cnt
   );
endinterface

// File: rtl/rf_issue_ctrl.sv
// rf_issue_ctrl: sequences one instruction at a time through register file
// read, ALU execution or memory access, and write-back.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : rf_issue_if.master (instruction handshake, register file,
//          ALU and memory controls, retire/err pulses, retired count)
// Parameter TIMEOUT_CYCLES sets the wait-state watchdog limit.
// Optional feature: define RF_ISSUE_TIMEOUT_EN to enable the watchdog on the
// EXEC and MEM wait states; without it the controller waits indefinitely.
module rf_issue_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic        clk,
   input logic        rst,
   rf_issue_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_WB} state_t;

   localparam logic [1:0] FUNC_RR  = 2'b00;
   localparam logic [1:0] FUNC_RI  = 2'b01;
   localparam logic [1:0] FUNC_MEM = 2'b10;
   localparam logic [1:0] FUNC_NOP = 2'b11;

   state_t     state;
   logic [1:0] func_q;
   logic       store_q;
   logic       to_idle_c;
   logic       timeout_c;
   logic       unused_sink;

   // Bit 28 of the instruction carries no meaning for this block.
   assign unused_sink = bus.inst_data[28] ^ (^32'(TIMEOUT_CYCLES));

`ifdef RF_ISSUE_TIMEOUT_EN
   localparam int unsigned WAIT_W = 16;
   logic [WAIT_W-1:0] wait_cnt;

   // Fires on the last permitted wait cycle that saw no done/ack.
   always_comb begin
      timeout_c = 1'b0;
      if (((state == S_EXEC) && !bus.alu_done) || ((state == S_MEM) && !bus.mem_ack))
         timeout_c = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
   end
`else
   assign timeout_c = 1'b0;
`endif

   // Transitions that restore every control output to its idle value.
   always_comb begin
      to_idle_c = timeout_c;
      case (state)
         S_WB:                   to_idle_c = 1'b1;
         S_MEM:                  if (bus.mem_ack && store_q) to_idle_c = 1'b1;
         S_IDLE, S_READ, S_EXEC: ;
         default:                to_idle_c = 1'b1;
      endcase
   end

   // Single-process FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         func_q         <= FUNC_NOP;
         store_q        <= 1'b0;
         bus.inst_ready <= 1'b1;
         bus.rf_func    <= FUNC_NOP;
         bus.rf_en_rg   <= 1'b0;
         bus.rf_addr    <= '0;
         bus.rf_imm     <= '0;
         bus.alu_op     <= '0;
         bus.alu_start  <= 1'b0;
         bus.mem_req    <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.retire     <= 1'b0;
         bus.err        <= 1'b0;
         bus.retire_cnt <= '0;
`ifdef RF_ISSUE_TIMEOUT_EN
         wait_cnt       <= '0;
`endif
      end else begin
         bus.alu_start <= 1'b0;
         bus.retire    <= 1'b0;
         bus.err       <= 1'b0;

         if (to_idle_c) begin
            state          <= S_IDLE;
            bus.inst_ready <= 1'b1;
            bus.rf_func    <= FUNC_NOP;
            bus.rf_en_rg   <= 1'b0;
            bus.rf_addr    <= '0;
            bus.rf_imm     <= '0;
            bus.alu_op     <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
         end

`ifdef RF_ISSUE_TIMEOUT_EN
         if (state == S_EXEC || state == S_MEM) wait_cnt <= wait_cnt + WAIT_W'(1);
         else                                   wait_cnt <= '0;
         if (timeout_c) bus.err <= 1'b1;
`endif

         case (state)
            S_IDLE: begin
               if (bus.inst_valid && bus.inst_ready) begin
                  func_q  <= bus.inst_data[31:30];
                  store_q <= bus.inst_data[29];
                  case (bus.inst_data[31:30])
                     FUNC_RR, FUNC_RI: begin
                        state          <= S_READ;
                        bus.inst_ready <= 1'b0;
                        bus.alu_op     <= bus.inst_data[27:24];
                        bus.rf_func    <= bus.inst_data[31:30];
                        bus.rf_en_rg   <= 1'b1;
                        if (bus.inst_data[30]) begin
                           bus.rf_imm  <= bus.inst_data[23:16];
                           bus.rf_addr <= {8'h00, bus.inst_data[15:0]};
                        end else begin
                           bus.rf_addr <= bus.inst_data[23:0];
                        end
                     end
                     FUNC_MEM: begin
                        bus.inst_ready <= 1'b0;
                        bus.alu_op     <= bus.inst_data[27:24];
                        bus.rf_addr    <= bus.inst_data[23:0];
                        if (bus.inst_data[29]) begin
                           // Store reads the source register first.
                           state        <= S_READ;
                           bus.rf_func  <= FUNC_MEM;
                           bus.rf_en_rg <= 1'b1;
                        end else begin
                           state        <= S_MEM;
                           bus.mem_req  <= 1'b1;
                           bus.mem_we   <= 1'b0;
                           bus.mem_addr <= bus.inst_data[23:8];
                        end
                     end
                     default: bus.err <= 1'b1;
                  endcase
               end
            end
            S_READ: begin
               bus.rf_func  <= FUNC_NOP;
               bus.rf_en_rg <= 1'b0;
               if (func_q == FUNC_MEM) begin
                  state        <= S_MEM;
                  bus.mem_req  <= 1'b1;
                  bus.mem_we   <= store_q;
                  bus.mem_addr <= bus.rf_addr[23:8];
               end else begin
                  state         <= S_EXEC;
                  bus.alu_start <= 1'b1;
               end
            end
            S_EXEC: begin
               if (bus.alu_done) begin
                  state          <= S_WB;
                  bus.rf_func    <= func_q;
                  bus.rf_en_rg   <= 1'b0;
                  bus.retire     <= 1'b1;
                  bus.retire_cnt <= bus.retire_cnt + 16'd1;
               end
            end
            S_MEM: begin
               if (bus.mem_ack) begin
                  bus.mem_req    <= 1'b0;
                  bus.mem_we     <= 1'b0;
                  bus.mem_addr   <= '0;
                  bus.retire     <= 1'b1;
                  bus.retire_cnt <= bus.retire_cnt + 16'd1;
                  if (!store_q) begin
                     // Load data is held by memory into the write-back cycle.
                     state        <= S_WB;
                     bus.rf_func  <= func_q;
                     bus.rf_en_rg <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rf_issue_ctrl.sv
// Directed testbench for rf_issue_ctrl: reset, reg-reg, reg-imm, store,
// load, illegal opcode, stray strobes, reset mid-EXEC and (when
// RF_ISSUE_TIMEOUT_EN is defined) the wait-state watchdog.
module tb_rf_issue_ctrl;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   rf_issue_if bus ();

   rf_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] inst);
      bus.inst_valid = 1'b1;
      bus.inst_data  = inst;
      tick();
      bus.inst_valid = 1'b0;
      bus.inst_data  = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.inst_valid = 1'b1;
      bus.inst_data  = 32'h0001_0005;
      tick();
      tick();
      n_vec++; if (bus.inst_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.inst_ready); end
      n_vec++; if (bus.rf_func !== 2'b11) begin n_err++; $display("FAIL reset_rf_func got %b want 11", bus.rf_func); end
      n_vec++; if (bus.rf_en_rg !== 1'b0 || bus.rf_addr !== 24'h0 || bus.rf_imm !== 8'h0) begin n_err++; $display("FAIL reset_rf got en=%b addr=%h imm=%h want 0", bus.rf_en_rg, bus.rf_addr, bus.rf_imm); end
      n_vec++; if (bus.alu_op !== 4'h0 || bus.alu_start !== 1'b0) begin n_err++; $display("FAIL reset_alu got op=%h start=%b want 0", bus.alu_op, bus.alu_start); end
      n_vec++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0) begin n_err++; $display("FAIL reset_mem got req=%b we=%b addr=%h want 0", bus.mem_req, bus.mem_we, bus.mem_addr); end
      n_vec++; if (bus.retire !== 1'b0 || bus.err !== 1'b0 || bus.retire_cnt !== 16'h0) begin n_err++; $display("FAIL reset_status got ret=%b err=%b cnt=%h want 0", bus.retire, bus.err, bus.retire_cnt); end
      bus.inst_valid = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reg_reg();
      issue(32'h0001_0005);
      n_vec++; if (bus.rf_func !== 2'b00 || bus.rf_en_rg !== 1'b1 || bus.rf_addr !== 24'h010005) begin n_err++; $display("FAIL rr_read got func=%b en=%b addr=%h want 00 1 010005", bus.rf_func, bus.rf_en_rg, bus.rf_addr); end
      n_vec++; if (bus.inst_ready !== 1'b0) begin n_err++; $display("FAIL rr_ready_low got %b want 0", bus.inst_ready); end
      tick();
      n_vec++; if (bus.alu_start !== 1'b1 || bus.rf_func !== 2'b11 || bus.rf_en_rg !== 1'b0) begin n_err++; $display("FAIL rr_exec got start=%b func=%b en=%b want 1 11 0", bus.alu_start, bus.rf_func, bus.rf_en_rg); end
      tick();
      n_vec++; if (bus.alu_start !== 1'b0 || bus.retire !== 1'b0) begin n_err++; $display("FAIL rr_wait got start=%b retire=%b want 0 0", bus.alu_start, bus.retire); end
      tick();
      bus.alu_done = 1'b1;
      tick();
      bus.alu_done = 1'b0;
      n_vec++; if (bus.retire !== 1'b1 || bus.rf_func !== 2'b00 || bus.rf_en_rg !== 1'b0 || bus.rf_addr[7:0] !== 8'h05) begin n_err++; $display("FAIL rr_wb got ret=%b func=%b en=%b rd=%h want 1 00 0 05", bus.retire, bus.rf_func, bus.rf_en_rg, bus.rf_addr[7:0]); end
      n_vec++; if (bus.retire_cnt !== 16'd1) begin n_err++; $display("FAIL rr_cnt got %0d want 1", bus.retire_cnt); end
      tick();
      n_vec++; if (bus.inst_ready !== 1'b1 || bus.retire !== 1'b0 || bus.rf_func !== 2'b11 || bus.rf_addr !== 24'h0) begin n_err++; $display("FAIL rr_idle got rdy=%b ret=%b func=%b addr=%h want 1 0 11 0", bus.inst_ready, bus.retire, bus.rf_func, bus.rf_addr); end
   endtask

   task automatic test_reg_imm();
      issue(32'h407F_0203);
      n_vec++; if (bus.rf_func !== 2'b01 || bus.rf_imm !== 8'h7F || bus.rf_addr !== 24'h000203) begin n_err++; $display("FAIL ri_read got func=%b imm=%h addr=%h want 01 7f 000203", bus.rf_func, bus.rf_imm, bus.rf_addr); end
      tick();
      bus.alu_done = 1'b1;
      n_vec++; if (bus.alu_start !== 1'b1) begin n_err++; $display("FAIL ri_start got %b want 1", bus.alu_start); end
      tick();
      bus.alu_done = 1'b0;
      n_vec++; if (bus.retire !== 1'b1 || bus.rf_func !== 2'b01 || bus.rf_en_rg !== 1'b0 || bus.rf_addr[7:0] !== 8'h03 || bus.retire_cnt !== 16'd2) begin n_err++; $display("FAIL ri_wb got ret=%b func=%b en=%b rd=%h cnt=%0d want 1 01 0 03 2", bus.retire, bus.rf_func, bus.rf_en_rg, bus.rf_addr[7:0], bus.retire_cnt); end
      tick();
   endtask

   task automatic test_store();
      issue(32'hA012_3402);
      n_vec++; if (bus.rf_func !== 2'b10 || bus.rf_en_rg !== 1'b1 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL st_read got func=%b en=%b req=%b want 10 1 0", bus.rf_func, bus.rf_en_rg, bus.mem_req); end
      tick();
      n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h1234 || bus.rf_func !== 2'b11) begin n_err++; $display("FAIL st_mem got req=%b we=%b addr=%h func=%b want 1 1 1234 11", bus.mem_req, bus.mem_we, bus.mem_addr, bus.rf_func); end
      tick();
      n_vec++; if (bus.mem_req !== 1'b1 || bus.retire !== 1'b0) begin n_err++; $display("FAIL st_hold got req=%b ret=%b want 1 0", bus.mem_req, bus.retire); end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      n_vec++; if (bus.retire !== 1'b1 || bus.mem_req !== 1'b0 || bus.rf_en_rg !== 1'b0 || bus.rf_func !== 2'b11 || bus.inst_ready !== 1'b1 || bus.retire_cnt !== 16'd3) begin n_err++; $display("FAIL st_done got ret=%b req=%b en=%b func=%b rdy=%b cnt=%0d want 1 0 0 11 1 3", bus.retire, bus.mem_req, bus.rf_en_rg, bus.rf_func, bus.inst_ready, bus.retire_cnt); end
      tick();
   endtask

   task automatic test_load();
      issue(32'h8012_3407);
      n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h1234 || bus.rf_en_rg !== 1'b0 || bus.inst_ready !== 1'b0) begin n_err++; $display("FAIL ld_mem got req=%b we=%b addr=%h en=%b rdy=%b want 1 0 1234 0 0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.rf_en_rg, bus.inst_ready); end
      tick();
      tick();
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      n_vec++; if (bus.retire !== 1'b1 || bus.rf_func !== 2'b10 || bus.rf_en_rg !== 1'b0 || bus.rf_addr[7:0] !== 8'h07 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL ld_wb got ret=%b func=%b en=%b rd=%h req=%b want 1 10 0 07 0", bus.retire, bus.rf_func, bus.rf_en_rg, bus.rf_addr[7:0], bus.mem_req); end
      n_vec++; if (bus.retire_cnt !== 16'd4) begin n_err++; $display("FAIL ld_cnt got %0d want 4", bus.retire_cnt); end
      tick();
   endtask

   task automatic test_illegal();
      issue(32'hC000_0000);
      n_vec++; if (bus.err !== 1'b1 || bus.rf_en_rg !== 1'b0 || bus.mem_req !== 1'b0 || bus.retire !== 1'b0) begin n_err++; $display("FAIL ill_err got err=%b en=%b req=%b ret=%b want 1 0 0 0", bus.err, bus.rf_en_rg, bus.mem_req, bus.retire); end
      n_vec++; if (bus.retire_cnt !== 16'd4) begin n_err++; $display("FAIL ill_cnt got %0d want 4", bus.retire_cnt); end
      tick();
      n_vec++; if (bus.err !== 1'b0 || bus.inst_ready !== 1'b1) begin n_err++; $display("FAIL ill_after got err=%b rdy=%b want 0 1", bus.err, bus.inst_ready); end
   endtask

   task automatic test_stray_strobes();
      bus.alu_done = 1'b1;
      bus.mem_ack  = 1'b1;
      tick();
      tick();
      bus.alu_done = 1'b0;
      bus.mem_ack  = 1'b0;
      n_vec++; if (bus.retire !== 1'b0 || bus.inst_ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.retire_cnt !== 16'd4) begin n_err++; $display("FAIL stray got ret=%b rdy=%b req=%b cnt=%0d want 0 1 0 4", bus.retire, bus.inst_ready, bus.mem_req, bus.retire_cnt); end
   endtask

`ifdef RF_ISSUE_TIMEOUT_EN
   task automatic test_timeout();
      issue(32'h8000_0001);
      for (int i = 0; i < 7; i++) tick();
      n_vec++; if (bus.mem_req !== 1'b1 || bus.err !== 1'b0) begin n_err++; $display("FAIL to_wait got req=%b err=%b want 1 0", bus.mem_req, bus.err); end
      tick();
      n_vec++; if (bus.err !== 1'b1 || bus.mem_req !== 1'b0 || bus.inst_ready !== 1'b1 || bus.retire !== 1'b0 || bus.retire_cnt !== 16'd4) begin n_err++; $display("FAIL to_fire got err=%b req=%b rdy=%b ret=%b cnt=%0d want 1 0 1 0 4", bus.err, bus.mem_req, bus.inst_ready, bus.retire, bus.retire_cnt); end
      tick();
   endtask
`endif

   task automatic test_reset_mid_exec();
      issue(32'h0002_0309);
      tick();
      n_vec++; if (bus.alu_start !== 1'b1) begin n_err++; $display("FAIL rx_exec got %b want 1", bus.alu_start); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++; if (bus.inst_ready !== 1'b1 || bus.rf_func !== 2'b11 || bus.retire !== 1'b0 || bus.retire_cnt !== 16'd0) begin n_err++; $display("FAIL rx_reset got rdy=%b func=%b ret=%b cnt=%0d want 1 11 0 0", bus.inst_ready, bus.rf_func, bus.retire, bus.retire_cnt); end
      bus.alu_done = 1'b1;
      tick();
      bus.alu_done = 1'b0;
      n_vec++; if (bus.retire !== 1'b0 || bus.rf_en_rg !== 1'b0) begin n_err++; $display("FAIL rx_nowb got ret=%b en=%b want 0 0", bus.retire, bus.rf_en_rg); end
      issue(32'h0003_0401);
      n_vec++; if (bus.rf_en_rg !== 1'b1 || bus.rf_addr !== 24'h030401) begin n_err++; $display("FAIL rx_next_read got en=%b addr=%h want 1 030401", bus.rf_en_rg, bus.rf_addr); end
      tick();
      bus.alu_done = 1'b1;
      tick();
      bus.alu_done = 1'b0;
      n_vec++; if (bus.retire !== 1'b1 || bus.retire_cnt !== 16'd1) begin n_err++; $display("FAIL rx_next_wb got ret=%b cnt=%0d want 1 1", bus.retire, bus.retire_cnt); end
      tick();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      bus.inst_valid = 1'b0;
      bus.inst_data  = 32'h0;
      bus.alu_done   = 1'b0;
      bus.mem_ack    = 1'b0;
      test_reset();
      test_reg_reg();
      test_reg_imm();
      test_store();
      test_load();
      test_illegal();
      test_stray_strobes();
`ifdef RF_ISSUE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_exec();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
